spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 21 ++
 rtl/spi_slave.sv | 111 +++++++++++
 tb/tb_spi_slave.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI master/memory side and spi_slave.
// rx_valid is a one-cycle pulse qualifying rx_data; tx_valid qualifies tx_data, with no ready/back-pressure.
interface spi_slave_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: collects 10-bit frames {cmd, payload} one bit per clk, and shifts
// read data back on MISO after a read-data command. State is exposed for checkers.
module spi_slave (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_if.slave        bus,
    output logic [2:0]        o_state,
    output logic              o_addr_seen
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_addr_seen;
    logic [3:0] r_bit_cnt;
    logic [8:0] r_rx_shift;
    logic       r_frame_done;
    logic [9:0] r_rx_data;
    logic       r_rx_valid;
    logic [7:0] r_tx_shift;
    logic [2:0] r_tx_cnt;
    logic       r_tx_loaded;
    logic       r_miso;
    logic       w_last_bit;

    assign w_last_bit = (r_bit_cnt == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr_seen  <= 1'b0;
            r_bit_cnt    <= 4'd0;
            r_rx_shift   <= 9'd0;
            r_frame_done <= 1'b0;
            r_rx_data    <= 10'h000;
            r_rx_valid   <= 1'b0;
            r_tx_shift   <= 8'd0;
            r_tx_cnt     <= 3'd0;
            r_tx_loaded  <= 1'b0;
            r_miso       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            // Deselect wins over everything, including the bit-0 sample.
            if (r_state != IDLE && bus.SS_n) begin
                r_state      <= IDLE;
                r_bit_cnt    <= 4'd0;
                r_rx_shift   <= 9'd0;
                r_frame_done <= 1'b0;
                r_tx_shift   <= 8'd0;
                r_tx_cnt     <= 3'd0;
                r_tx_loaded  <= 1'b0;
                r_miso       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!bus.SS_n) r_state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        r_rx_shift <= {8'h00, bus.MOSI};
                        r_bit_cnt  <= 4'd0;
                        if (!bus.MOSI)       r_state <= WRITE;
                        else if (r_addr_seen) r_state <= READ_DATA;
                        else                  r_state <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_frame_done) begin
                            r_rx_shift <= {r_rx_shift[7:0], bus.MOSI};
                            if (w_last_bit) begin
                                r_rx_data    <= {r_rx_shift, bus.MOSI};
                                r_rx_valid   <= 1'b1;
                                r_frame_done <= 1'b1;
                                if (r_state == READ_ADD)  r_addr_seen <= 1'b1;
                                if (r_state == READ_DATA) r_addr_seen <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else if (r_state == READ_DATA) begin
                            // Bit 7 goes straight to MISO on the latch edge; seven more follow.
                            if (!r_tx_loaded && bus.tx_valid) begin
                                r_tx_loaded <= 1'b1;
                                r_miso      <= bus.tx_data[7];
                                r_tx_shift  <= {bus.tx_data[6:0], 1'b0};
                                r_tx_cnt    <= 3'd7;
                            end else if (r_tx_cnt != 3'd0) begin
                                r_miso     <= r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_tx_cnt   <= r_tx_cnt - 3'd1;
                            end else begin
                                r_miso <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.MISO     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign o_state      = r_state;
    assign o_addr_seen  = r_addr_seen;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frames driven bit by bit, outputs checked #1 after the rising edge.
module tb_spi_slave;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_READ_ADD  = 3'd3;
    localparam logic [2:0] ST_READ_DATA = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] state;
    logic       addr_seen;
    int         tests_run = 0;
    int         tests_failed = 0;
    int         pulse_cnt = 0;

    spi_slave_if bus_if ();

    spi_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .o_state     (state),
        .o_addr_seen (addr_seen)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_if.rx_valid === 1'b1) pulse_cnt++;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task start_frame;
        bus_if.SS_n = 1'b0;
        tick;
    endtask

    task shift_bits(input logic [9:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bus_if.MOSI = f[i];
            tick;
        end
    endtask

    task end_frame;
        bus_if.SS_n = 1'b1;
        bus_if.MOSI = 1'b0;
        tick;
    endtask

    task test_reset;
        rst_n = 1'b0;
        bus_if.SS_n = 1'b1;
        bus_if.MOSI = 1'b0;
        bus_if.tx_data = 8'h00;
        bus_if.tx_valid = 1'b0;
        tick;
        tick;
        tests_run++;
        if (state !== ST_IDLE || addr_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state actual=%0d/%0b required=0/0", state, addr_seen);
        end
        tests_run++;
        if (bus_if.rx_data !== 10'h000 || bus_if.rx_valid !== 1'b0 || bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs actual=%h/%b/%b required=000/0/0", bus_if.rx_data, bus_if.rx_valid, bus_if.MISO);
        end
        #2 rst_n = 1'b1;
        tick;
    endtask

    task test_write_addr;
        int p0;
        p0 = pulse_cnt;
        start_frame;
        shift_bits(10'h0A5, 9, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== 10'h0A5) begin
            tests_failed++;
            $display("FAIL wr_addr_pulse actual=%b/%h required=1/0a5", bus_if.rx_valid, bus_if.rx_data);
        end
        tests_run++;
        if (state !== ST_WRITE || addr_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_addr_state actual=%0d/%b required=2/0", state, addr_seen);
        end
        shift_bits(10'h3FF, 2, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b0 || bus_if.rx_data !== 10'h0A5 || pulse_cnt - p0 != 1) begin
            tests_failed++;
            $display("FAIL wr_addr_hold actual=%b/%h/%0d required=0/0a5/1", bus_if.rx_valid, bus_if.rx_data, pulse_cnt - p0);
        end
        end_frame;
        tests_run++;
        if (state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL wr_addr_idle actual=%0d required=0", state);
        end
    endtask

    task test_write_data;
        int p0;
        p0 = pulse_cnt;
        start_frame;
        shift_bits(10'h13C, 9, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== 10'h13C || bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_data_pulse actual=%b/%h/%b required=1/13c/0", bus_if.rx_valid, bus_if.rx_data, bus_if.MISO);
        end
        tick;
        tick;
        tests_run++;
        if (pulse_cnt - p0 != 1 || bus_if.MISO !== 1'b0 || addr_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_data_single actual=%0d/%b/%b required=1/0/0", pulse_cnt - p0, bus_if.MISO, addr_seen);
        end
        end_frame;
    endtask

    task test_read;
        logic [7:0] exp_byte;
        exp_byte = 8'hC3;
        start_frame;
        shift_bits(10'h207, 9, 0);
        tests_run++;
        if (bus_if.rx_data !== 10'h207 || addr_seen !== 1'b1 || state !== ST_READ_ADD) begin
            tests_failed++;
            $display("FAIL rd_addr actual=%h/%b/%0d required=207/1/3", bus_if.rx_data, addr_seen, state);
        end
        tick;
        tests_run++;
        if (bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_addr_miso actual=%b required=0", bus_if.MISO);
        end
        end_frame;
        start_frame;
        shift_bits(10'h35A, 9, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data[9:8] !== 2'b11 || addr_seen !== 1'b0 || state !== ST_READ_DATA) begin
            tests_failed++;
            $display("FAIL rd_data_frame actual=%b/%h/%b/%0d required=1/35a/0/4", bus_if.rx_valid, bus_if.rx_data, addr_seen, state);
        end
        tick;
        tests_run++;
        if (bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_wait_miso actual=%b required=0", bus_if.MISO);
        end
        bus_if.tx_data = 8'hC3;
        bus_if.tx_valid = 1'b1;
        tick;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            tests_run++;
            if (bus_if.MISO !== exp_byte[i]) begin
                tests_failed++;
                $display("FAIL rd_miso_bit%0d actual=%b required=%b", i, bus_if.MISO, exp_byte[i]);
            end
            tick;
        end
        tests_run++;
        if (bus_if.MISO !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_miso_after actual=%b required=0", bus_if.MISO);
        end
        bus_if.tx_valid = 1'b1;
        tick;
        bus_if.tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus_if.MISO !== 1'b0) begin
                tests_failed++;
                $display("FAIL rd_second_txv actual=%b required=0", bus_if.MISO);
            end
            tick;
        end
        end_frame;
    endtask

    task test_abort;
        int p0;
        p0 = pulse_cnt;
        start_frame;
        shift_bits(10'h0A5, 9, 5);
        end_frame;
        tests_run++;
        if (state !== ST_IDLE || pulse_cnt != p0 || bus_if.rx_data !== 10'h35A) begin
            tests_failed++;
            $display("FAIL abort_5bits actual=%0d/%0d/%h required=0/0/35a", state, pulse_cnt - p0, bus_if.rx_data);
        end
        start_frame;
        shift_bits(10'h0F0, 9, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== 10'h0F0) begin
            tests_failed++;
            $display("FAIL abort_next_frame actual=%b/%h required=1/0f0", bus_if.rx_valid, bus_if.rx_data);
        end
        end_frame;
        start_frame;
        shift_bits(10'h2AA, 9, 0);
        end_frame;
        p0 = pulse_cnt;
        start_frame;
        shift_bits(10'h3C1, 9, 1);
        bus_if.SS_n = 1'b1;
        bus_if.MOSI = 1'b1;
        tick;
        tests_run++;
        if (state !== ST_IDLE || pulse_cnt != p0 || addr_seen !== 1'b1 || bus_if.rx_data !== 10'h2AA) begin
            tests_failed++;
            $display("FAIL abort_bit0 actual=%0d/%0d/%b/%h required=0/0/1/2aa", state, pulse_cnt - p0, addr_seen, bus_if.rx_data);
        end
    endtask

    task test_async_reset;
        start_frame;
        shift_bits(10'h3FF, 9, 0);
        tests_run++;
        if (state !== ST_READ_DATA || addr_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL ar_rd_frame actual=%0d/%b required=4/0", state, addr_seen);
        end
        bus_if.tx_data = 8'hFF;
        bus_if.tx_valid = 1'b1;
        tick;
        bus_if.tx_valid = 1'b0;
        tick;
        tests_run++;
        if (bus_if.MISO !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar_shifting actual=%b required=1", bus_if.MISO);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_if.MISO !== 1'b0 || bus_if.rx_valid !== 1'b0 || addr_seen !== 1'b0 || state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL ar_shift_reset actual=%b/%b/%b/%0d required=0/0/0/0", bus_if.MISO, bus_if.rx_valid, addr_seen, state);
        end
        bus_if.SS_n = 1'b1;
        #2 rst_n = 1'b1;
        tick;
        start_frame;
        shift_bits(10'h2C4, 9, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || addr_seen !== 1'b1 || bus_if.rx_data !== 10'h2C4) begin
            tests_failed++;
            $display("FAIL ar_ra_frame actual=%b/%b/%h required=1/1/2c4", bus_if.rx_valid, addr_seen, bus_if.rx_data);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_if.rx_valid !== 1'b0 || addr_seen !== 1'b0 || bus_if.rx_data !== 10'h000 || state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL ar_pulse_reset actual=%b/%b/%h/%0d required=0/0/000/0", bus_if.rx_valid, addr_seen, bus_if.rx_data, state);
        end
        bus_if.SS_n = 1'b1;
        #2 rst_n = 1'b1;
        tick;
        start_frame;
        shift_bits(10'h0C3, 9, 0);
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== 10'h0C3) begin
            tests_failed++;
            $display("FAIL ar_fresh_frame actual=%b/%h required=1/0c3", bus_if.rx_valid, bus_if.rx_data);
        end
        end_frame;
    endtask

    task test_spurious_txv;
        logic [9:0] f;
        f = 10'h155;
        bus_if.tx_data = 8'hFF;
        bus_if.tx_valid = 1'b1;
        start_frame;
        for (int i = 9; i >= 0; i--) begin
            bus_if.MOSI = f[i];
            tick;
            tests_run++;
            if (bus_if.MISO !== 1'b0 || state !== ST_WRITE) begin
                tests_failed++;
                $display("FAIL spur_bit%0d actual=%b/%0d required=0/2", i, bus_if.MISO, state);
            end
        end
        tests_run++;
        if (bus_if.rx_valid !== 1'b1 || bus_if.rx_data !== 10'h155) begin
            tests_failed++;
            $display("FAIL spur_pulse actual=%b/%h required=1/155", bus_if.rx_valid, bus_if.rx_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            tests_run++;
            if (bus_if.MISO !== 1'b0 || state !== ST_WRITE || addr_seen !== 1'b0) begin
                tests_failed++;
                $display("FAIL spur_after actual=%b/%0d/%b required=0/2/0", bus_if.MISO, state, addr_seen);
            end
        end
        bus_if.tx_valid = 1'b0;
        end_frame;
    endtask

    initial begin
        test_reset;
        test_write_addr;
        test_write_data;
        test_read;
        test_abort;
        test_async_reset;
        test_spurious_txv;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
